// File: rtl/neuraedge_pe_drain.sv
// neuraedge_pe_drain
// Result-drain controller for one row of PEs. A start command snapshots all
// PE accumulators, pulses the PE clear, then streams each accumulator out,
// requantized to OUT_WIDTH bits (rounding arithmetic right shift followed by
// saturation), one element per valid/ready beat.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   drain_start   start command, honoured only in IDLE
//   shift         right-shift amount, sampled with drain_start
//   accum_in      flattened PE accumulators, PE i at [i*ACCUM_WIDTH +: ACCUM_WIDTH]
//   pe_clear      one-cycle pulse to the PE mac_clear inputs
//   busy          drain in progress
//   out_data      requantized element
//   out_idx       PE index of out_data
//   out_last      marks the element from PE NUM_PE-1
//   out_valid     output beat valid
//   out_ready     downstream accept
//   done          one-cycle pulse after the final beat is accepted
module neuraedge_pe_drain #(
    parameter int NUM_PE      = 8,
    parameter int ACCUM_WIDTH = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int IDX_WIDTH   = $clog2(NUM_PE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          drain_start,
    input  logic [4:0]                    shift,
    input  logic [NUM_PE*ACCUM_WIDTH-1:0] accum_in,
    output logic                          pe_clear,
    output logic                          busy,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [IDX_WIDTH-1:0]          out_idx,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          done
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PE - 1);

    // Saturation bounds expressed in the widened ACCUM_WIDTH+1 domain.
    localparam logic signed [ACCUM_WIDTH:0] SAT_MAX =
        {{(ACCUM_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACCUM_WIDTH:0] SAT_MIN =
        {{(ACCUM_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    state_t                               state;
    logic [NUM_PE-1:0][ACCUM_WIDTH-1:0]   shadow;
    logic [4:0]                           shift_q;
    logic [IDX_WIDTH-1:0]                 nxt_idx;

    // One extra bit of headroom keeps the rounding add from overflowing,
    // e.g. 0x7FFFFFFF + 2^30 at shift 31.
    function automatic logic [OUT_WIDTH-1:0] requant(
        input logic [ACCUM_WIDTH-1:0] a,
        input logic [4:0]             sh
    );
        logic signed [ACCUM_WIDTH:0] ext;
        logic signed [ACCUM_WIDTH:0] rnd;
        logic signed [ACCUM_WIDTH:0] r;
        ext = {a[ACCUM_WIDTH-1], a};
        if (sh == 5'd0) begin
            rnd = ext;
            r   = ext;
        end else begin
            rnd = ext + ({{ACCUM_WIDTH{1'b0}}, 1'b1} << (sh - 5'd1));
            r   = rnd >>> sh;
        end
        if (r > SAT_MAX)
            r = SAT_MAX;
        else if (r < SAT_MIN)
            r = SAT_MIN;
        return r[OUT_WIDTH-1:0];
    endfunction

    assign nxt_idx = out_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pe_clear  <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            pe_clear <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (drain_start) begin
                        shadow    <= accum_in;
                        shift_q   <= shift;
                        pe_clear  <= 1'b1;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                        out_last  <= 1'b0;
                        // Element 0 comes straight from the live inputs so
                        // it is on the bus the cycle after the command.
                        out_data  <= requant(accum_in[ACCUM_WIDTH-1:0], shift);
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (out_idx != LAST_IDX) begin
                            out_idx  <= nxt_idx;
                            out_last <= (nxt_idx == LAST_IDX);
                            out_data <= requant(shadow[nxt_idx], shift_q);
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
